// File: rtl/random_block_interleaver.sv
// rtl/random_block_interleaver.sv - block interleaver/deinterleaver with LFSR-derived permutation
module random_block_interleaver #(
    parameter int          N    = 1024,
    parameter int          W    = 1,
    parameter int unsigned SEED = 1,
    parameter int unsigned TAPS = 'h240
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int L = $clog2(N);
    localparam logic [L-1:0] SEED_L   = SEED[L-1:0];
    localparam logic [L-1:0] TAPS_L   = TAPS[L-1:0];
    localparam logic [L-1:0] CNT_ONE  = {{(L-1){1'b0}}, 1'b1};
    localparam logic [L-1:0] CNT_LAST = {L{1'b1}};

    typedef enum logic {S_LOAD, S_DRAIN} state_t;

    state_t       state;
    logic [L-1:0] cnt;
    logic [L-1:0] lfsr;       // holds p(max(cnt,1)); p(0) = 0 is handled separately
    logic         mode_q;
    logic [W-1:0] mem [N];

    logic [L-1:0] cur_perm;
    logic [L-1:0] nxt_perm;
    logic [L-1:0] cnt_nxt;
    logic [L-1:0] wr_addr;
    logic [L-1:0] rd_addr;
    logic         in_fire;
    logic         out_fire;

    // Permutation addressing for the current index and the one after it
    always_comb begin
        cur_perm = (cnt == '0) ? '0 : lfsr;
        // p(1) = SEED already sits in the LFSR, so the first step from index 0 keeps it
        nxt_perm = (cnt == '0) ? lfsr : {lfsr[L-2:0], ^(lfsr & TAPS_L)};
        cnt_nxt  = cnt + CNT_ONE;
        // at cnt = 0 both choices are address 0, so the not-yet-latched mode is harmless
        wr_addr  = mode_q ? cur_perm : cnt;
        // drain reads one index ahead so the registered output is ready on acceptance
        rd_addr  = mode_q ? cnt_nxt : nxt_perm;
        in_fire  = (state == S_LOAD) && in_valid;
        out_fire = out_valid && out_ready;
        in_ready = (state == S_LOAD);
    end

    // Symbol storage; contents are don't-care after reset so no reset branch
    always_ff @(posedge clock) begin
        if (in_fire) begin
            mem[wr_addr] <= in_data;
        end
    end

    // Load/drain sequencing, counters, LFSR and registered output stage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_LOAD;
            cnt       <= '0;
            lfsr      <= SEED_L;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else if (state == S_LOAD) begin
            if (in_valid) begin
                busy <= 1'b1;
                if (cnt == '0) begin
                    mode_q <= mode;
                end
                if (cnt == CNT_LAST) begin
                    // address 0 is written by the first symbol in both modes, so it is safe to read now
                    state     <= S_DRAIN;
                    cnt       <= '0;
                    lfsr      <= SEED_L;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    out_data  <= mem['0];
                end else begin
                    cnt  <= cnt_nxt;
                    lfsr <= nxt_perm;
                end
            end
        end else begin
            if (out_fire) begin
                if (cnt == CNT_LAST) begin
                    state     <= S_LOAD;
                    cnt       <= '0;
                    lfsr      <= SEED_L;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    cnt      <= cnt_nxt;
                    lfsr     <= nxt_perm;
                    out_data <= mem[rd_addr];
                    out_last <= (cnt_nxt == CNT_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_random_block_interleaver.sv
// tb/tb_random_block_interleaver.sv - directed bench for random_block_interleaver at N=8, W=8
module tb_random_block_interleaver;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        m;
        logic        stall;
        logic        toggle;
        logic [63:0] din;
        logic [63:0] dexp;
    } vec_t;

    vec_t vecs [7];

    random_block_interleaver #(.N(8), .W(8), .SEED(1), .TAPS(6)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_block(input string name, input vec_t v);
        int         ni = 0;
        int         no = 0;
        int         cyc = 0;
        bit         prev_stall = 0;
        logic [7:0] held = 8'h00;
        while (no < 8 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            chk($sformatf("%s ctl c%0d", name, cyc), {busy, in_ready, out_valid},
                {ni > 0, ni < 8, ni == 8});
            if (prev_stall) chk($sformatf("%s hold c%0d", name, cyc), out_data, held);
            prev_stall = 0;
            if (ni < 8) begin
                in_valid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = v.din[8*ni +: 8];
                mode     = (v.toggle && ni >= 3) ? ~v.m : v.m;
                if (in_valid && in_ready) ni++;
            end else begin
                in_valid = v.stall ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data  = 8'hEE;
            end
            out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                chk($sformatf("%s last j%0d", name, no), out_last, no == 7);
                if (out_ready) begin
                    chk($sformatf("%s data j%0d", name, no), out_data, v.dexp[8*no +: 8]);
                    no++;
                end else begin
                    prev_stall = 1;
                    held = out_data;
                end
            end
        end
        if (no < 8) chk($sformatf("%s timeout", name), no, 8);
    endtask

    initial begin
        vecs[0] = '{m: 1'b0, stall: 1'b0, toggle: 1'b0, din: pk(0,1,2,3,4,5,6,7), dexp: pk(0,1,2,5,3,7,6,4)};
        vecs[1] = '{m: 1'b1, stall: 1'b0, toggle: 1'b0, din: pk(0,1,2,3,4,5,6,7), dexp: pk(0,1,2,4,7,3,6,5)};
        vecs[2] = '{m: 1'b0, stall: 1'b0, toggle: 1'b0, din: pk(0,1,2,4,7,3,6,5), dexp: pk(0,1,2,3,4,5,6,7)};
        vecs[3] = '{m: 1'b0, stall: 1'b1, toggle: 1'b0, din: pk(0,1,2,3,4,5,6,7), dexp: pk(0,1,2,5,3,7,6,4)};
        vecs[4] = '{m: 1'b1, stall: 1'b1, toggle: 1'b0, din: pk(0,1,2,3,4,5,6,7), dexp: pk(0,1,2,4,7,3,6,5)};
        vecs[5] = '{m: 1'b0, stall: 1'b0, toggle: 1'b1,
                    din: pk('hA0,'hA1,'hA2,'hA3,'hA4,'hA5,'hA6,'hA7),
                    dexp: pk('hA0,'hA1,'hA2,'hA5,'hA3,'hA7,'hA6,'hA4)};
        vecs[6] = '{m: 1'b1, stall: 1'b0, toggle: 1'b0, din: pk(0,1,2,5,3,7,6,4), dexp: pk(0,1,2,3,4,5,6,7)};

        repeat (2) @(negedge clock);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_last", out_last, 1'b0);
        chk("rst out_data", out_data, 8'h00);
        chk("rst busy", busy, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst in_ready", in_ready, 1'b1);

        // table of blocks, run back to back
        for (int i = 0; i < 7; i++) run_block($sformatf("vec%0d", i), vecs[i]);

        // three consecutive identical blocks: busy gap of one cycle is covered by the ctl check
        for (int b = 0; b < 3; b++)
            run_block($sformatf("b2b%0d", b),
                      '{m: 1'b0, stall: 1'b0, toggle: 1'b0,
                        din: pk('h30,'h31,'h32,'h33,'h34,'h35,'h36,'h37),
                        dexp: pk('h30,'h31,'h32,'h35,'h33,'h37,'h36,'h34)});

        // reset after four inputs of a block
        @(negedge clock);
        out_ready = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'h50 + 8'(i);
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("midload busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midload rst out_valid", out_valid, 1'b0);
        chk("midload rst busy", busy, 1'b0);
        @(negedge clock);
        chk("midload rst out_valid2", out_valid, 1'b0);
        reset_n = 1'b1;
        run_block("after_midload", '{m: 1'b0, stall: 1'b0, toggle: 1'b0,
                                     din: pk(10,11,12,13,14,15,16,17), dexp: pk(10,11,12,15,13,17,16,14)});

        // reset in the middle of a drain
        @(negedge clock);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = 8'h60 + 8'(i);
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("middrain valid", out_valid, 1'b1);
        chk("middrain d0", out_data, 8'h60);
        out_ready = 1'b1;
        @(negedge clock);
        chk("middrain d1", out_data, 8'h61);
        out_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("middrain rst state", {out_valid, out_last, busy, out_data}, 11'h000);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("middrain release", {in_ready, out_valid}, 2'b10);
        run_block("after_middrain", vecs[0]);

        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        chk("final idle", {busy, in_ready, out_valid}, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
